// File: rtl/soin_bpred_pkg.sv
// soin_bpred_pkg -- shared definitions for the branch-predictor update path.
//
// Contents:
//   - table geometry constants (index, counter and RAS-index widths)
//   - bit offsets of the fields packed into the 24-bit fetch meta word
//   - bp_entry_t: one pending predictor-table write {index, ctr_byte, be}
//   - lane_onehot(): byte-enable lane decode
package soin_bpred_pkg;

    localparam int BP_IDX_W     = 8;
    localparam int BP_CTR_W     = 2;
    localparam int BP_RAS_IDX_W = 4;
    localparam int BP_BYTE_W    = 8;
    localparam int BP_BE_W      = 4;

    // Fetch meta layout: [7:0] table index, [15:8] counter byte, [23:20] RAS index.
    localparam int META_W        = 24;
    localparam int META_IDX_LSB  = 0;
    localparam int META_BYTE_LSB = 8;
    localparam int META_RAS_LSB  = 20;

    // A pending table write. The counter byte holds four 2-bit counters.
    typedef struct packed {
        logic [BP_IDX_W-1:0]  index;
        logic [BP_BYTE_W-1:0] ctr_byte;
        logic [BP_BE_W-1:0]   be;
    } bp_entry_t;

    localparam int BP_ENTRY_W = $bits(bp_entry_t);

    // Decode a 2-bit lane number into a one-hot byte enable.
    function automatic logic [BP_BE_W-1:0] lane_onehot(input logic [1:0] lane);
        logic [BP_BE_W-1:0] be;
        case (lane)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            2'd3:    be = 4'b1000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/soin_bpred_ctr_update.sv
// soin_bpred_ctr_update -- replaces one 2-bit saturating counter in a byte.
//
// Ports:
//   byte_in  [7:0] : counter byte holding four 2-bit counters
//   k        [1:0] : which counter to update (bits [2k+1:2k])
//   taken          : resolved direction; taken increments, not-taken decrements
//   byte_out [7:0] : byte_in with counter k saturating-updated
module soin_bpred_ctr_update
    import soin_bpred_pkg::*;
(
    input  logic [BP_BYTE_W-1:0] byte_in,
    input  logic [1:0]           k,
    input  logic                 taken,
    output logic [BP_BYTE_W-1:0] byte_out
);

    logic [BP_CTR_W-1:0] ctr_s;
    logic [BP_CTR_W-1:0] ctr_next_s;

    // Extract the selected counter field.
    always_comb begin
        ctr_s = 2'd0;
        case (k)
            2'd0:    ctr_s = byte_in[1:0];
            2'd1:    ctr_s = byte_in[3:2];
            2'd2:    ctr_s = byte_in[5:4];
            2'd3:    ctr_s = byte_in[7:6];
            default: ctr_s = 2'd0;
        endcase
    end

    // Saturating increment on taken, saturating decrement on not-taken.
    always_comb begin
        ctr_next_s = ctr_s;
        if (taken) begin
            if (ctr_s == 2'd3) begin
                ctr_next_s = 2'd3;
            end else begin
                ctr_next_s = ctr_s + 2'd1;
            end
        end else begin
            if (ctr_s == 2'd0) begin
                ctr_next_s = 2'd0;
            end else begin
                ctr_next_s = ctr_s - 2'd1;
            end
        end
    end

    // Write the updated counter back into its field, leaving the others intact.
    always_comb begin
        byte_out = byte_in;
        case (k)
            2'd0:    byte_out[1:0] = ctr_next_s;
            2'd1:    byte_out[3:2] = ctr_next_s;
            2'd2:    byte_out[5:4] = ctr_next_s;
            2'd3:    byte_out[7:6] = ctr_next_s;
            default: byte_out      = byte_in;
        endcase
    end

endmodule

// File: rtl/soin_bpred_update.sv
// soin_bpred_update -- branch resolution handling and predictor update queue.
//
// Resolved instructions from execute are checked for a misprediction (which
// produces a one-cycle registered redirect plus RAS recovery request) and, for
// branches, turned into a predictor-table write that is queued in a DEPTH-entry
// FIFO. The head of the FIFO drives the table write port and drains whenever
// the predictor is not stalling.
//
// Optional feature: define SOIN_BPU_COALESCE_EN to merge a new update into the
// tail entry when it targets the same index and byte lane.
//
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready               : input handshake
//   in_is_branch, in_taken, in_pred_dir, in_pc, in_target, in_pred_target, in_meta
//   redirect_valid, redirect_pc, recover_ras, recover_ras_index : registered
//   wr_en, wr_index, wr_data, wr_be : predictor table write port (queue head)
//   bpredictor_stall                : holds the queue head
//   occupancy                       : current queue entry count
module soin_bpred_update
    import soin_bpred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_is_branch,
    input  logic                      in_taken,
    input  logic                      in_pred_dir,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_target,
    input  logic [31:0]               in_pred_target,
    input  logic [META_W-1:0]         in_meta,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic                      recover_ras,
    output logic [BP_RAS_IDX_W-1:0]   recover_ras_index,
    output logic                      wr_en,
    output logic [BP_IDX_W-1:0]       wr_index,
    output logic [BP_BYTE_W-1:0]      wr_data,
    output logic [BP_BE_W-1:0]        wr_be,
    input  logic                      bpredictor_stall,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    bp_entry_t            mem_r [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [OCC_W-1:0]     occ_r;

    logic                 accept_s;
    logic                 br_acc_s;
    logic                 miss_s;
    logic                 enq_s;
    logic                 deq_s;
    logic                 merge_s;
    logic [1:0]           k_s;
    logic [BP_BE_W-1:0]   be_s;
    logic [BP_IDX_W-1:0]  meta_idx_s;
    logic [BP_BYTE_W-1:0] meta_byte_s;
    logic [BP_BYTE_W-1:0] base_byte_s;
    logic [BP_BYTE_W-1:0] new_byte_s;
    bp_entry_t            new_entry_s;
    bp_entry_t            head_s;
    logic                 unused_meta_s;

    assign meta_idx_s  = in_meta[META_IDX_LSB +: BP_IDX_W];
    assign meta_byte_s = in_meta[META_BYTE_LSB +: BP_BYTE_W];
    assign unused_meta_s = ^in_meta[META_RAS_LSB-1:META_BYTE_LSB+BP_BYTE_W];

    // in_ready comes from registered occupancy only, never from this cycle's dequeue.
    assign in_ready  = (occ_r < OCC_W'(DEPTH));
    assign occupancy = occ_r;

    assign accept_s = in_valid & in_ready;
    assign br_acc_s = accept_s & in_is_branch;
    assign miss_s   = in_is_branch &
                      ((in_taken != in_pred_dir) | (in_taken & (in_target != in_pred_target)));

    assign k_s  = in_pc[3:2];
    assign be_s = lane_onehot(in_pc[5:4]);

    assign head_s   = mem_r[rd_ptr_r];
    assign wr_index = head_s.index;
    assign wr_data  = head_s.ctr_byte;
    assign wr_be    = head_s.be;
    assign wr_en    = (occ_r != {OCC_W{1'b0}}) & ~bpredictor_stall;
    assign deq_s    = wr_en;

`ifdef SOIN_BPU_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr_s;
    bp_entry_t        tail_s;
    logic             tail_deq_s;

    assign tail_ptr_s = wr_ptr_r - PTR_W'(1);
    assign tail_s     = mem_r[tail_ptr_s];
    // The tail is only leaving this edge when it is also the head.
    assign tail_deq_s = deq_s & (occ_r == OCC_W'(1));
    assign merge_s    = br_acc_s & (occ_r != {OCC_W{1'b0}}) &
                        (tail_s.index == meta_idx_s) & (tail_s.be == be_s) & ~tail_deq_s;
    // A merge continues counting from the queued byte, not the stale fetch copy.
    assign base_byte_s = merge_s ? tail_s.ctr_byte : meta_byte_s;
`else
    assign merge_s     = 1'b0;
    assign base_byte_s = meta_byte_s;
`endif

    assign enq_s = br_acc_s & ~merge_s;

    soin_bpred_ctr_update u_ctr_update (
        .byte_in  (base_byte_s),
        .k        (k_s),
        .taken    (in_taken),
        .byte_out (new_byte_s)
    );

    assign new_entry_s = {meta_idx_s, new_byte_s, be_s};

    // Queue storage: allocate at the write pointer or merge into the tail.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {BP_ENTRY_W{1'b0}};
            end
        end else begin
            if (enq_s) begin
                mem_r[wr_ptr_r] <= new_entry_s;
            end
`ifdef SOIN_BPU_COALESCE_EN
            else if (merge_s) begin
                mem_r[tail_ptr_s].ctr_byte <= new_byte_s;
            end
`endif
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks enq/deq.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Registered redirect and RAS recovery, valid for the single cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_valid    <= 1'b0;
            redirect_pc       <= 32'd0;
            recover_ras       <= 1'b0;
            recover_ras_index <= {BP_RAS_IDX_W{1'b0}};
        end else begin
            redirect_valid <= br_acc_s & miss_s;
            recover_ras    <= br_acc_s & miss_s;
            if (br_acc_s) begin
                redirect_pc       <= in_taken ? in_target : (in_pc + 32'd4);
                recover_ras_index <= in_meta[META_RAS_LSB +: BP_RAS_IDX_W];
            end
        end
    end

endmodule

// File: doc/soin_bpred_update.md
SOIN_BPRED_UPDATE -- requirements
Module: soin_bpred_update

Interface
REQ-001 SHALL have parameter DEPTH, default 4: update-queue entries, a power of two, 2 to 16.
REQ-002 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: resolved instruction from execute.
REQ-005 SHALL have port in_ready, output, 1: queue can accept.
REQ-006 SHALL have ports in_is_branch 1, in_taken 1, in_pred_dir 1, in_pc 32, in_target 32, in_pred_target 32, all inputs: resolution and prediction data.
REQ-007 SHALL have port in_meta, input, 24: fetch meta, bits [7:0] index, [15:8] counter byte, [23:20] RAS index.
REQ-008 SHALL have ports redirect_valid 1, redirect_pc 32, recover_ras 1, recover_ras_index 4, all outputs.
REQ-009 SHALL have ports wr_en 1, wr_index 8, wr_data 8, wr_be 4, all outputs: predictor table write port.
REQ-010 SHALL have port bpredictor_stall, input, 1: blocks the queue drain.
REQ-011 SHALL have port occupancy, output, clog2(DEPTH)+1: current entry count.

Function
REQ-012 SHALL accept an input on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (occupancy<DEPTH) and SHALL not depend on dequeue in the same cycle.
REQ-013 SHALL discard an accepted input with in_is_branch=0: no enqueue and no redirect.
REQ-014 SHALL compute miss = in_is_branch & ((in_taken!=in_pred_dir) | (in_taken & in_target!=in_pred_target)).
REQ-015 SHALL, for a branch accepted at edge N, drive redirect_valid=miss for exactly the cycle after N (registered).
REQ-016 SHALL drive redirect_pc = in_taken ? in_target : in_pc+4, computed modulo 2^32.
REQ-017 SHALL drive recover_ras=miss and recover_ras_index=in_meta[23:20] with the same timing as redirect_valid.
REQ-018 SHALL select counter field c = in_meta[15:8] bits [2k+1:2k], where k=in_pc[3:2].
REQ-019 SHALL update c as a 2-bit saturating counter: taken gives min(c+1,3), not-taken gives max(c-1,0).
REQ-020 SHALL form each entry as {index=in_meta[7:0], byte=in_meta[15:8] with field k replaced, be=one-hot of in_pc[5:4]}.
REQ-021 SHALL present the head entry combinationally on wr_index, wr_data and wr_be.
REQ-022 SHALL drive wr_en = (occupancy!=0) & !bpredictor_stall; the head SHALL dequeue on an edge where wr_en=1.
REQ-023 SHALL give an entry enqueued at edge N into an empty queue wr_en=1 in cycle N+1; there is no same-cycle bypass.
REQ-024 SHALL enqueue and dequeue in the same edge when not full and not stalled, leaving occupancy unchanged.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL hold all entries while bpredictor_stall=1 and keep accepting inputs until full.

Reset
REQ-027 SHALL, on reset=0 at an edge, clear occupancy and both pointers and drive redirect_valid, recover_ras and wr_en to 0, discarding queued updates and any in-flight redirect.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, when macro SOIN_BPU_COALESCE_EN is defined, merge a branch update into the tail entry when the queue is non-empty, the index and be match, and the tail is not dequeuing that edge.
REQ-030 SHALL, on a merge, recompute field k from the tail byte rather than in_meta, with occupancy unchanged.
REQ-031 SHALL, without SOIN_BPU_COALESCE_EN, always allocate a new entry.

Structure
REQ-032 SHALL place in shared package soin_bpred_pkg: the meta field offsets and the constants BP_IDX_W=8, BP_CTR_W=2, BP_RAS_IDX_W=4.
REQ-033 SHALL place in soin_bpred_pkg the entry struct {index, byte, be}.
REQ-034 SHALL implement the counter arithmetic in sub-module soin_bpred_ctr_update (byte, k, taken -> new byte).

Verification
REQ-035 SHALL cover: meta byte 0xFF, pc 0x104, taken -> wr_data 0xFF, wr_be 0b0001, wr_index=meta[7:0].
REQ-036 SHALL cover: meta byte 0x00, pc 0x10C, not-taken -> wr_data 0x00, wr_be 0b0001.
REQ-037 SHALL cover: pred_dir 1, taken 0, pc 0x200 -> redirect_valid for one cycle, redirect_pc 0x204, recover_ras_index=meta[23:20].
REQ-038 SHALL cover: pred_dir 1, taken 1, target 0x400, pred_target 0x480 -> redirect_pc 0x400.
REQ-039 SHALL cover: bpredictor_stall=1, 5 branches pushed with DEPTH=4 -> in_ready=0 after 4; after stall release 4 writes in order on consecutive cycles.
REQ-040 SHALL cover: reset pulse while occupancy 3 with a miss in flight -> next cycle occupancy 0, wr_en 0, redirect_valid 0; with COALESCE_EN, two taken updates to the same index/lane from counter 1 -> single entry with counter 3.
